// File: rtl/svm_weight_bank_ctrl.sv
// rtl/svm_weight_bank_ctrl.sv - double-buffered weight/bias bank with drain-then-swap commit (option: SVM_PARTIAL_COMMIT_EN)
module svm_weight_bank_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_FEATURES = 16,
  parameter int IDX_WIDTH    = 5,
  parameter int PIPE_LATENCY = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [IDX_WIDTH-1:0]               cfg_addr,
  input  logic [DATA_WIDTH-1:0]              cfg_data,
  input  logic                               cfg_commit,
  output logic                               cfg_err,
  output logic                               commit_done,
  output logic [7:0]                         model_version,
  input  logic                               feat_valid,
  output logic                               feat_ready,
  input  logic [DATA_WIDTH*NUM_FEATURES-1:0] feat_flat,
  output logic                               svm_input_valid,
  output logic [DATA_WIDTH*NUM_FEATURES-1:0] svm_features_flat,
  output logic [DATA_WIDTH*NUM_FEATURES-1:0] weights_flat,
  output logic [DATA_WIDTH-1:0]              bias,
  input  logic                               svm_output_valid,
  output logic [3:0]                         inflight
);

  // entries 0..NUM_FEATURES-1 are weights, entry NUM_FEATURES is the bias
  localparam int NE    = NUM_FEATURES + 1;
  localparam int CNT_W = $clog2(PIPE_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shadow [NE];
  logic [NE-1:0]         mask;
  logic [CNT_W-1:0]      cnt;

  logic                  in_idle;
  logic                  addr_ok;
  logic                  wr_ok;
  logic                  wr_bad;
  logic                  commit_take;
  logic                  commit_ok;
  logic                  commit_rej;
  logic                  feat_take;
  logic [NE-1:0]         wr_bit;
  logic [NE-1:0]         mask_next;
  logic [NE-1:0]         copy_en;

  // ready is held low while reset is asserted, high whenever the bank is idle
  assign in_idle     = (state == IDLE);
  assign cfg_ready   = rst_n & in_idle;
  assign feat_ready  = rst_n & in_idle;
  assign inflight    = 4'(cnt);

  assign addr_ok     = (cfg_addr <= IDX_WIDTH'(NUM_FEATURES));
  assign wr_ok       = in_idle & cfg_valid & addr_ok;
  assign wr_bad      = in_idle & cfg_valid & ~addr_ok;
  assign commit_take = in_idle & cfg_commit;
  assign feat_take   = in_idle & feat_valid;
  assign mask_next   = mask | wr_bit;

  // one-hot of the entry being written this cycle, so a same-cycle write counts toward the commit
  always_comb begin
    wr_bit = '0;
    if (wr_ok) wr_bit[cfg_addr] = 1'b1;
  end

`ifdef SVM_PARTIAL_COMMIT_EN
  // partial mode: any commit proceeds and only freshly written entries are copied
  assign commit_ok  = commit_take;
  assign commit_rej = 1'b0;
  assign copy_en    = mask;
`else
  // full mode: a commit needs every weight and the bias rewritten since the last swap
  assign commit_ok  = commit_take & (&mask_next);
  assign commit_rej = commit_take & ~(&mask_next);
  assign copy_en    = '1;
`endif

  // control FSM, shadow/active banks, feature register and in-flight counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      mask              <= '0;
      cnt               <= '0;
      cfg_err           <= 1'b0;
      commit_done       <= 1'b0;
      model_version     <= 8'd0;
      svm_input_valid   <= 1'b0;
      svm_features_flat <= '0;
      weights_flat      <= '0;
      bias              <= '0;
      for (int i = 0; i < NE; i++) shadow[i] <= '0;
    end else begin
      cfg_err         <= wr_bad | commit_rej;
      commit_done     <= 1'b0;
      svm_input_valid <= feat_take;
      if (feat_take) svm_features_flat <= feat_flat;
      if (wr_ok) begin
        shadow[cfg_addr] <= cfg_data;
        mask             <= mask_next;
      end

      // a launch and a retire in the same cycle cancel; never underflow
      case ({svm_input_valid, svm_output_valid})
        2'b10:   if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        2'b01:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      case (state)
        IDLE: begin
          if (commit_ok) state <= DRAIN;
        end
        DRAIN: begin
          if (cnt == '0 && !svm_input_valid) state <= SWAP;
        end
        SWAP: begin
          for (int i = 0; i < NUM_FEATURES; i++) begin
            if (copy_en[i]) weights_flat[i*DATA_WIDTH +: DATA_WIDTH] <= shadow[i];
          end
          if (copy_en[NUM_FEATURES]) bias <= shadow[NUM_FEATURES];
          model_version <= model_version + 8'd1;
          mask          <= '0;
          commit_done   <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_weight_bank_ctrl.sv
// tb/tb_svm_weight_bank_ctrl.sv - directed self-checking bench for svm_weight_bank_ctrl
module tb_svm_weight_bank_ctrl;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [4:0]   cfg_addr;
  logic [15:0]  cfg_data;
  logic         cfg_commit;
  logic         cfg_err;
  logic         commit_done;
  logic [7:0]   model_version;
  logic         feat_valid;
  logic         feat_ready;
  logic [255:0] feat_flat;
  logic         svm_input_valid;
  logic [255:0] svm_features_flat;
  logic [255:0] weights_flat;
  logic [15:0]  bias;
  logic         svm_output_valid;
  logic [3:0]   inflight;

  int checks;
  int failures;
  logic [15:0]  exp_w [16];
  logic [15:0]  exp_b;
  logic [7:0]   exp_ver;
  logic [255:0] fv;

  svm_weight_bank_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .cfg_commit        (cfg_commit),
    .cfg_err           (cfg_err),
    .commit_done       (commit_done),
    .model_version     (model_version),
    .feat_valid        (feat_valid),
    .feat_ready        (feat_ready),
    .feat_flat         (feat_flat),
    .svm_input_valid   (svm_input_valid),
    .svm_features_flat (svm_features_flat),
    .weights_flat      (weights_flat),
    .bias              (bias),
    .svm_output_valid  (svm_output_valid),
    .inflight          (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack_w();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = exp_w[i];
    return v;
  endfunction

  task automatic wr(input int addr, input logic [15:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = 5'(addr);
    cfg_data  = data;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic write_model(input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < 16; i++) wr(i, w);
    wr(16, b);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_weights"}, weights_flat, pack_w());
    check_eq({tag, "_bias"}, 256'(bias), 256'(exp_b));
    check_eq({tag, "_version"}, 256'(model_version), 256'(exp_ver));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    feat_valid = 1'b0; feat_flat = '0; svm_output_valid = 1'b0;
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0000;
    exp_b = 16'h0000; exp_ver = 8'd0;

    // reset state
    repeat (3) tick;
    check_eq("rst_cfg_ready", 256'(cfg_ready), 256'(0));
    check_eq("rst_feat_ready", 256'(feat_ready), 256'(0));
    check_eq("rst_inflight", 256'(inflight), 256'(0));
    check_eq("rst_sviv", 256'(svm_input_valid), 256'(0));
    check_eq("rst_err_done", 256'({cfg_err, commit_done}), 256'(0));
    check_model("rst");
    rst_n = 1'b1;
    #1;
    check_eq("rel_cfg_ready", 256'(cfg_ready), 256'(1));
    check_eq("rel_feat_ready", 256'(feat_ready), 256'(1));
    tick;

    // full model, commit with idle pipeline -> commit_done 3 cycles later
    write_model(16'h0100, 16'hFF00);
    cfg_commit = 1'b1;
    tick;
    cfg_commit = 1'b0;
    check_eq("c1_done_p1", 256'(commit_done), 256'(0));
    check_eq("c1_ready_p1", 256'(cfg_ready), 256'(0));
    tick;
    check_eq("c1_done_p2", 256'(commit_done), 256'(0));
    check_model("c1_p2_old");
    tick;
    check_eq("c1_done_p3", 256'(commit_done), 256'(1));
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0100;
    exp_b = 16'hFF00; exp_ver = 8'd1;
    check_model("c1_p3");
    check_eq("c1_err", 256'(cfg_err), 256'(0));
    tick;
    check_eq("c1_done_p4", 256'(commit_done), 256'(0));
    check_eq("c1_ready_p4", 256'(cfg_ready), 256'(1));

    // stream 6 features, commit after last accept, drain
    write_model(16'h0200, 16'h0080);
    for (int k = 0; k < 6; k++) begin
      fv = {16{16'(k + 1)}};
      feat_valid = 1'b1;
      feat_flat  = fv;
      tick;
      check_eq($sformatf("s_sviv_%0d", k), 256'(svm_input_valid), 256'(1));
      check_eq($sformatf("s_feat_%0d", k), svm_features_flat, fv);
    end
    feat_valid = 1'b0;
    cfg_commit = 1'b1;
    tick;
    cfg_commit = 1'b0;
    check_eq("d_feat_ready", 256'(feat_ready), 256'(0));
    check_eq("d_inflight6", 256'(inflight), 256'(6));
    feat_valid = 1'b1;
    feat_flat  = {16{16'h00AA}};
    for (int k = 0; k < 6; k++) begin
      svm_output_valid = 1'b1;
      tick;
      check_eq($sformatf("d_sviv_%0d", k), 256'(svm_input_valid), 256'(0));
      check_eq($sformatf("d_infl_%0d", k), 256'(inflight), 256'(5 - k));
      check_eq($sformatf("d_ready_%0d", k), 256'(cfg_ready), 256'(0));
      check_eq($sformatf("d_done_%0d", k), 256'(commit_done), 256'(0));
      check_model($sformatf("d_old_%0d", k));
    end
    svm_output_valid = 1'b0;
    feat_valid = 1'b0;
    tick;
    check_eq("d_swap_done", 256'(commit_done), 256'(0));
    check_model("d_swap_old");
    tick;
    check_eq("d_done", 256'(commit_done), 256'(1));
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0200;
    exp_b = 16'h0080; exp_ver = 8'd2;
    check_model("d_new");
    check_eq("d_feat_keep", svm_features_flat, {16{16'h0006}});
    tick;

    // incomplete mask: addrs 0..14 only, then commit
    for (int i = 0; i < 15; i++) wr(i, 16'h0300);
    cfg_commit = 1'b1;
    tick;
    cfg_commit = 1'b0;
`ifdef SVM_PARTIAL_COMMIT_EN
    check_eq("p_err", 256'(cfg_err), 256'(0));
    check_eq("p_ready", 256'(cfg_ready), 256'(0));
    tick; tick;
    check_eq("p_done", 256'(commit_done), 256'(1));
    for (int i = 0; i < 15; i++) exp_w[i] = 16'h0300;
    exp_ver = exp_ver + 8'd1;
    check_model("p_model");
    tick;
`else
    check_eq("p_err", 256'(cfg_err), 256'(1));
    check_eq("p_ready", 256'(cfg_ready), 256'(1));
    tick;
    check_eq("p_err_clr", 256'(cfg_err), 256'(0));
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("p_nodone_%0d", k), 256'(commit_done), 256'(0));
      tick;
    end
    check_model("p_model");
`endif

    // bad addresses, then final write plus commit in the same cycle
    wr(20, 16'hDEAD);
    check_eq("a20_err", 256'(cfg_err), 256'(1));
    tick;
    check_eq("a20_err_clr", 256'(cfg_err), 256'(0));
    wr(17, 16'hBEEF);
    check_eq("a17_err", 256'(cfg_err), 256'(1));
    wr(15, 16'h0400);
    check_eq("a15_err", 256'(cfg_err), 256'(0));
    cfg_valid = 1'b1; cfg_addr = 5'd16; cfg_data = 16'h0500; cfg_commit = 1'b1;
    tick;
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    check_eq("sc_err", 256'(cfg_err), 256'(0));
    check_eq("sc_ready", 256'(cfg_ready), 256'(0));
    tick; tick;
    check_eq("sc_done", 256'(commit_done), 256'(1));
    for (int i = 0; i < 15; i++) exp_w[i] = 16'h0300;
    exp_w[15] = 16'h0400; exp_b = 16'h0500; exp_ver = exp_ver + 8'd1;
    check_model("sc");
    tick;

    // simultaneous launch/retire keeps inflight constant; retire at zero saturates
    feat_valid = 1'b1; feat_flat = {16{16'h0011}};
    repeat (3) tick;
    check_eq("h_infl_pre", 256'(inflight), 256'(2));
    svm_output_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      check_eq($sformatf("h_infl_%0d", k), 256'(inflight), 256'(2));
    end
    feat_valid = 1'b0;
    tick;
    check_eq("h_tail_a", 256'(inflight), 256'(2));
    tick;
    check_eq("h_tail_b", 256'(inflight), 256'(1));
    tick;
    check_eq("h_tail_c", 256'(inflight), 256'(0));
    tick;
    check_eq("h_sat0", 256'(inflight), 256'(0));
    svm_output_valid = 1'b0;
    tick;

    // reset asserted mid-DRAIN drops the pending commit
    write_model(16'h0600, 16'h0700);
    feat_valid = 1'b1; feat_flat = {16{16'h0033}};
    tick;
    feat_valid = 1'b0;
    cfg_commit = 1'b1;
    tick;
    cfg_commit = 1'b0;
    check_eq("r_drain_ready", 256'(cfg_ready), 256'(0));
    check_eq("r_drain_infl", 256'(inflight), 256'(1));
    rst_n = 1'b0;
    #1;
    check_eq("r_cfg_ready", 256'(cfg_ready), 256'(0));
    check_eq("r_inflight", 256'(inflight), 256'(0));
    check_eq("r_feat", svm_features_flat, 256'(0));
    for (int i = 0; i < 16; i++) exp_w[i] = 16'h0000;
    exp_b = 16'h0000; exp_ver = 8'd0;
    check_model("r_zero");
    tick;
    rst_n = 1'b1;
    tick;
    check_eq("r_rel_ready", 256'(cfg_ready), 256'(1));
    check_eq("r_rel_fready", 256'(feat_ready), 256'(1));
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("r_nodone_%0d", k), 256'(commit_done), 256'(0));
      tick;
    end
    check_model("r_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
